// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register for the 5-stage MIPS core.
// Flush inserts a bubble, stall holds; saturating bubble/stall counters aid perf debug.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic              MemToRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RdD,
    input  logic              CntClr,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              MemToRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  RdE,
    output logic [REG_W-1:0]  WriteRegE,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              memToReg;
        logic              memWrite;
        logic              aluSrc;
        logic              regDst;
        logic [ALUC_W-1:0] aluControl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signImm;
        logic [DATA_W-1:0] pcPlus4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } idExT;

    idExT stageD;
    idExT stageE;

    // An invalid D slot still carries its fields, but must not write the RF or memory.
    always_comb begin
        stageD            = '0;
        stageD.valid      = ValidD;
        stageD.regWrite   = RegWriteD & ValidD;
        stageD.memToReg   = MemToRegD & ValidD;
        stageD.memWrite   = MemWriteD & ValidD;
        stageD.aluSrc     = ALUSrcD;
        stageD.regDst     = RegDstD;
        stageD.aluControl = ALUControlD;
        stageD.rd1        = RD1D;
        stageD.rd2        = RD2D;
        stageD.signImm    = SignImmD;
        stageD.pcPlus4    = PCPlus4D;
        stageD.rs         = RsD;
        stageD.rt         = RtD;
        stageD.rd         = RdD;
    end

    // Zeroed specifiers on flush keep the hazard unit from seeing a forwarding match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stageE <= '0;
        else if (FlushE)
            stageE <= '0;
        else if (!StallE)
            stageE <= stageD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            BubbleCnt <= '0;
        else if (CntClr)
            BubbleCnt <= '0;
        else if (FlushE && BubbleCnt != '1)
            BubbleCnt <= BubbleCnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCnt <= '0;
        else if (CntClr)
            StallCnt <= '0;
        else if (StallE && !FlushE && StallCnt != '1)
            StallCnt <= StallCnt + 1'b1;
    end

    assign ValidE      = stageE.valid;
    assign RegWriteE   = stageE.regWrite;
    assign MemToRegE   = stageE.memToReg;
    assign MemWriteE   = stageE.memWrite;
    assign ALUSrcE     = stageE.aluSrc;
    assign RegDstE     = stageE.regDst;
    assign ALUControlE = stageE.aluControl;
    assign RD1E        = stageE.rd1;
    assign RD2E        = stageE.rd2;
    assign SignImmE    = stageE.signImm;
    assign PCPlus4E    = stageE.pcPlus4;
    assign RsE         = stageE.rs;
    assign RtE         = stageE.rt;
    assign RdE         = stageE.rd;
    assign WriteRegE   = stageE.regDst ? stageE.rd : stageE.rt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: driver predicts each edge into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALUC_W = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              FlushE, StallE, ValidD, CntClr;
    logic              RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
    logic [REG_W-1:0]  RsD, RtD, RdD;
    logic              ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, SignImmE, PCPlus4E;
    logic [REG_W-1:0]  RsE, RtE, RdE, WriteRegE;
    logic [CNT_W-1:0]  BubbleCnt, StallCnt;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .StallE(StallE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .CntClr(CntClr),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .PCPlus4E(PCPlus4E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
        .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid, regWrite, memToReg, memWrite, aluSrc, regDst;
        logic [ALUC_W-1:0] aluc;
        logic [DATA_W-1:0] rd1, rd2, imm, pc;
        logic [REG_W-1:0]  rs, rt, rd;
    } fieldsT;

    typedef struct {
        fieldsT f;
        int     bub;
        int     stl;
    } expT;

    expT    sbq[$];
    fieldsT m;
    int     bub, stl;
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic fieldsT actual();
        fieldsT a;
        a = '{ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
              RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE};
        return a;
    endfunction

    // Reference: what E should hold after this edge, from the stage's rules.
    task automatic modelEdge();
        expT e;
        if (!rst_n) begin
            m = '0; bub = 0; stl = 0;
        end else begin
            if (CntClr) begin
                bub = 0; stl = 0;
            end else if (FlushE) begin
                bub = (bub >= CMAX) ? CMAX : bub + 1;
            end else if (StallE) begin
                stl = (stl >= CMAX) ? CMAX : stl + 1;
            end
            if (FlushE) m = '0;
            else if (!StallE) begin
                m.valid    = ValidD;
                m.regWrite = ValidD ? RegWriteD : 1'b0;
                m.memToReg = ValidD ? MemToRegD : 1'b0;
                m.memWrite = ValidD ? MemWriteD : 1'b0;
                m.aluSrc   = ALUSrcD;
                m.regDst   = RegDstD;
                m.aluc     = ALUControlD;
                m.rd1 = RD1D; m.rd2 = RD2D; m.imm = SignImmD; m.pc = PCPlus4D;
                m.rs = RsD; m.rt = RtD; m.rd = RdD;
            end
        end
        e.f = m; e.bub = bub; e.stl = stl;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            expT e;
            logic [REG_W-1:0] wr;
            e  = sbq.pop_front();
            wr = e.f.regDst ? e.f.rd : e.f.rt;
            chk("efields",   256'(actual()),  256'(e.f));
            chk("writereg",  256'(WriteRegE), 256'(wr));
            chk("bubblecnt", 256'(BubbleCnt), 256'(e.bub));
            chk("stallcnt",  256'(StallCnt),  256'(e.stl));
        end
    end

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        #1;
    endtask

    task automatic randD();
        ValidD      = ($urandom_range(0, 3) != 0);
        RegWriteD   = 1'($urandom); MemToRegD = 1'($urandom); MemWriteD = 1'($urandom);
        ALUSrcD     = 1'($urandom); RegDstD   = 1'($urandom);
        ALUControlD = ALUC_W'($urandom);
        RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom; PCPlus4D = $urandom;
        RsD = REG_W'($urandom); RtD = REG_W'($urandom); RdD = REG_W'($urandom);
    endtask

    task automatic zeroD();
        {ValidD, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD} = '0;
        ALUControlD = '0; RD1D = '0; RD2D = '0; SignImmD = '0; PCPlus4D = '0;
        RsD = '0; RtD = '0; RdD = '0;
    endtask

    initial begin
        m = '0; bub = 0; stl = 0;
        rst_n = 1'b0; FlushE = 0; StallE = 0; CntClr = 0;
        randD(); ValidD = 1; RegWriteD = 1; RsD = 3;
        // Reset with nonzero D inputs: everything stays 0.
        step();
        step();
        rst_n = 1'b1;

        // Plain load, then re-select destination.
        zeroD();
        ValidD = 1; RegWriteD = 1; RsD = 5; RtD = 6; RdD = 7; RegDstD = 1;
        RD1D = 32'hDEAD_BEEF;
        step();
        chk("dir_writereg7", 256'(WriteRegE), 256'(7));
        RegDstD = 0;
        step();
        chk("dir_writereg6", 256'(WriteRegE), 256'(6));

        // Load-use bubble: flush wins over stall.
        FlushE = 1; StallE = 1;
        step();
        chk("dir_flush_valid", 256'(ValidE), 256'(0));
        FlushE = 0; StallE = 0;

        // Load something, hold it for three stalled edges, then release.
        randD(); ValidD = 1;
        step();
        StallE = 1;
        repeat (3) begin randD(); step(); end
        chk("dir_stall3", 256'(StallCnt), 256'(3));
        StallE = 0; randD();
        step();

        // Invalid slot suppresses side effects but keeps specifiers.
        zeroD(); ValidD = 0; RegWriteD = 1; MemWriteD = 1; MemToRegD = 1; RsD = 9;
        step();
        chk("dir_invalid_rs", 256'(RsE), 256'(9));

        // Bubble counter saturation, then clear beats coincident increment.
        FlushE = 1;
        repeat (20) step();
        chk("dir_bub_sat", 256'(BubbleCnt), 256'(CMAX));
        CntClr = 1;
        step();
        CntClr = 0; FlushE = 0;

        // Async reset mid-flush takes effect before any edge.
        randD(); ValidD = 1; StallE = 1;
        step();
        StallE = 0; FlushE = 1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_fields", 256'(actual()), 256'(0));
        chk("async_cnts", 256'({BubbleCnt, StallCnt, WriteRegE}), 256'(0));
        step();
        rst_n = 1'b1; FlushE = 0;

        // Randomized traffic with occasional reset, clear, flush and stall.
        for (int i = 0; i < 400; i++) begin
            randD();
            FlushE = ($urandom_range(0, 9) == 0);
            StallE = ($urandom_range(0, 3) == 0);
            CntClr = ($urandom_range(0, 29) == 0);
            rst_n  = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1'b1;

        for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
        #1;
        chk("sb_drained", 256'(sbq.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
